// File: rtl/r0_pkg.sv
// Shared types and constants for the reaction-timer result store:
// BCD digit types, default widths and the score FSM state encoding.
package r0_pkg;

  localparam int W_BIN  = 20;
  localparam int N_DIG  = 6;
  localparam int MAX_US = 999999;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [N_DIG-1:0] bcd6_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } score_state_e;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
// the whole {bcd, binary} vector left by one bit.
module bcd_dabble_step #(
  parameter int N_DIG = 6,
  parameter int W_BIN = 20
) (
  input  logic [4*N_DIG+W_BIN-1:0] din,
  output logic [4*N_DIG+W_BIN-1:0] dout
);

  logic [4*N_DIG+W_BIN-1:0] adj;

  always_comb begin
    adj = din;
    for (int d = 0; d < N_DIG; d++) begin
      if (din[W_BIN+4*d +: 4] >= 4'd5) begin
        adj[W_BIN+4*d +: 4] = din[W_BIN+4*d +: 4] + 4'd3;
      end
    end
    dout = {adj[4*N_DIG+W_BIN-2:0], 1'b0};
  end

endmodule

// File: rtl/score_bcd.sv
// Reaction-timer result store: saturates each new time, converts it serially
// to packed BCD and keeps the last and best results for the text layout.
module score_bcd #(
  parameter int W_BIN  = 20,
  parameter int N_DIG  = 6,
  parameter int MAX_US = 999999
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [W_BIN-1:0]   i_us,
  input  logic               i_clear,
  input  logic               i_sel,
  output logic [4*N_DIG-1:0] o_bcd,
  output logic               o_init,
  output logic               o_busy,
  output logic               o_new,
  output logic               o_record
);

  import r0_pkg::score_state_e;
  import r0_pkg::ST_IDLE;
  import r0_pkg::ST_CONV;
  import r0_pkg::ST_COMMIT;

  localparam int                 SH_W    = 4*N_DIG + W_BIN;
  localparam int                 CNT_W   = $clog2(W_BIN + 1);
  localparam logic [W_BIN-1:0]   MAX_SAT = W_BIN'(MAX_US);
  localparam logic [CNT_W-1:0]   LAST_IT = CNT_W'(W_BIN - 1);

  score_state_e       state;
  logic [CNT_W-1:0]   cnt;
  logic [SH_W-1:0]    shreg;
  logic [SH_W-1:0]    step_out;
  logic [W_BIN-1:0]   sat;
  logic [W_BIN-1:0]   sat_q;
  logic [W_BIN-1:0]   best_bin;
  logic               best_valid;
  logic [4*N_DIG-1:0] last_bcd;
  logic [4*N_DIG-1:0] best_bcd;

  // Saturating before conversion keeps every digit in 0..9.
  assign sat = (i_us > MAX_SAT) ? MAX_SAT : i_us;

  bcd_dabble_step #(
    .N_DIG (N_DIG),
    .W_BIN (W_BIN)
  ) u_step (
    .din  (shreg),
    .dout (step_out)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      sat_q      <= '0;
      best_bin   <= '0;
      best_valid <= 1'b0;
      last_bcd   <= '0;
      best_bcd   <= '0;
      o_init     <= 1'b1;
      o_new      <= 1'b0;
      o_record   <= 1'b0;
    end else begin
      o_new    <= 1'b0;
      o_record <= 1'b0;
      // Clear aborts any conversion and beats a simultaneous i_valid.
      if (i_clear) begin
        state      <= ST_IDLE;
        cnt        <= '0;
        best_bin   <= '0;
        best_valid <= 1'b0;
        last_bcd   <= '0;
        best_bcd   <= '0;
        o_init     <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_valid) begin
              sat_q <= sat;
              shreg <= {{(4*N_DIG){1'b0}}, sat};
              cnt   <= '0;
              state <= ST_CONV;
            end
          end
          ST_CONV: begin
            shreg <= step_out;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_IT) begin
              state <= ST_COMMIT;
            end
          end
          ST_COMMIT: begin
            last_bcd <= shreg[SH_W-1:W_BIN];
            // A tie keeps the earlier best and raises no record pulse.
            if (!best_valid || (sat_q < best_bin)) begin
              best_bcd   <= shreg[SH_W-1:W_BIN];
              best_bin   <= sat_q;
              best_valid <= 1'b1;
              o_record   <= 1'b1;
            end
            o_new  <= 1'b1;
            o_init <= 1'b0;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_busy = (state != ST_IDLE);
  assign o_bcd  = i_sel ? best_bcd : last_bcd;

endmodule
